// File: rtl/rational_crossing_pkg.sv
// Shared definitions for the rational clock crossing (source and sink ends).
// Provides the 2-bit Johnson token type, its four legal values in sequence
// order, and the single-step advance function used by both ends.
package rational_crossing_pkg;

   typedef logic [1:0] rc_token_t;

   // Token sequence: 00 -> 01 -> 11 -> 10 -> 00
   localparam rc_token_t RC_TOK0 = 2'b00;
   localparam rc_token_t RC_TOK1 = 2'b01;
   localparam rc_token_t RC_TOK2 = 2'b11;
   localparam rc_token_t RC_TOK3 = 2'b10;

   function automatic rc_token_t rc_next(input rc_token_t t);
      return {t[0], ~t[1]};
   endfunction

endpackage

// File: rtl/crossing_skid_queue.sv
// Small FIFO used as the registered front end of the crossing source.
// Ports:
//   clk_i, rst_i   clock and synchronous active-high reset
//   push_valid_i   write request (caller qualifies it with its own ready)
//   push_bits_i    write data
//   pop_ready_i    read request; a pop happens only when not empty
//   pop_bits_o     head entry, forced to zero while empty
//   full_o         no free slot at the start of the cycle
//   empty_o        no valid entry at the start of the cycle
module crossing_skid_queue #(
   parameter int W     = 64,
   parameter int DEPTH = 2
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         push_valid_i,
   input  logic [W-1:0] push_bits_i,
   input  logic         pop_ready_i,
   output logic [W-1:0] pop_bits_o,
   output logic         full_o,
   output logic         empty_o
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [W-1:0]  mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          push, pop;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign full_o  = (cnt_q == CW'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign pop     = pop_ready_i & ~empty_o;
   // A push while full is taken only when a pop frees a slot in the same cycle;
   // the incoming beat lands in the slot being vacated and occupancy holds.
   assign push    = push_valid_i & (~full_o | pop);

   // Empty queue presents zero so the head never shows a stale entry.
   assign pop_bits_o = empty_o ? '0 : mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) mem_q[wr_ptr_q] <= push_bits_i;
   end

endmodule

// File: rtl/rational_crossing_source.sv
// Sender end of a rational-ratio clock crossing for one channel. Everything
// runs on the sender clock; the sink's ready/token arrive from an
// integer-ratio related clock and are only used combinationally.
// A Johnson token (x_source) paired with the sink's echoed token (x_sink)
// bounds the crossing to at most two beats in flight.
// Ports:
//   clock, reset   sender clock, synchronous active-high reset
//   enq_valid/enq_ready/enq_bits   upstream beat handshake and payload
//   x_bits0        payload of the beat currently offered
//   x_bits1        copy of the payload held for slow-side sampling
//   x_valid        crossing valid
//   x_source       token of the beat on x_bits0
//   x_ready        sink ready
//   x_sink         sink's token (next token it expects)
module rational_crossing_source
   import rational_crossing_pkg::*;
#(
   parameter int W       = 64,
   parameter bit ENQ_REG = 1'b1
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         enq_valid,
   output logic         enq_ready,
   input  logic [W-1:0] enq_bits,
   output logic [W-1:0] x_bits0,
   output logic [W-1:0] x_bits1,
   output logic         x_valid,
   output rc_token_t    x_source,
   input  logic         x_ready,
   input  rc_token_t    x_sink
);

   rc_token_t    count_q, count_d;
   logic [W-1:0] bits1_q, bits1_d;
   logic         head_valid;
   logic [W-1:0] head_bits;
   logic         equal, may_fire, fire_x;

   assign equal = (count_q == x_sink);
   // In step with the sink: follow its ready. Otherwise the top token bit
   // against the sink's low bit decides whether one beat of run-ahead is free.
   assign may_fire = equal ? x_ready : (count_q[1] != x_sink[0]);
   assign fire_x   = head_valid & may_fire;

   if (ENQ_REG) begin : g_skid
      logic q_full, q_empty;

      crossing_skid_queue #(.W(W), .DEPTH(2)) u_queue (
         .clk_i        (clock),
         .rst_i        (reset),
         .push_valid_i (enq_valid & enq_ready),
         .push_bits_i  (enq_bits),
         .pop_ready_i  (may_fire),
         .pop_bits_o   (head_bits),
         .full_o       (q_full),
         .empty_o      (q_empty)
      );

      assign head_valid = ~q_empty;
      assign enq_ready  = ~q_full & ~reset;
   end else begin : g_direct
      assign head_valid = enq_valid;
      assign head_bits  = enq_bits;
      assign enq_ready  = may_fire & ~reset;
   end

   assign x_valid  = head_valid & ~reset;
   assign x_bits0  = reset ? '0 : head_bits;
   assign x_source = count_q;
   assign x_bits1  = bits1_q;

   always_comb begin
      count_d = count_q;
      bits1_d = bits1_q;
      if (fire_x) count_d = rc_next(count_q);
      // The held copy tracks the head whenever the sink is in step, fired or not.
      if (equal)  bits1_d = head_bits;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         count_q <= RC_TOK0;
         bits1_q <= '0;
      end else begin
         count_q <= count_d;
         bits1_q <= bits1_d;
      end
   end

`ifndef SYNTHESIS
   a_sink_not_ahead: assert property (@(posedge clock) disable iff (reset)
      x_sink != rc_next(rc_next(count_q)));
   a_hold_until_fire: assert property (@(posedge clock) disable iff (reset)
      (x_valid && !fire_x) |=> (x_valid && $stable(x_bits0)));
`endif

endmodule

// File: tb/tb_rational_crossing_source.sv
module tb_rational_crossing_source;

   int   tests = 0;
   int   fails = 0;
   logic clk   = 1'b0;
   bit   done [4];

   always #5 clk = ~clk;

   // Token of the n-th beat: the four-step Johnson sequence by position.
   function automatic logic [1:0] tok(input int n);
      case (n % 4)
         0:       return 2'b00;
         1:       return 2'b01;
         2:       return 2'b11;
         default: return 2'b10;
      endcase
   endfunction

   function automatic logic [63:0] rnd();
      return {$urandom, $urandom};
   endfunction

   task automatic check(input int cfg, input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         if (fails <= 40)
            $display("FAIL cfg%0d %s: got %0h, expected %0h", cfg, name, act, exp);
      end
   endtask

   // cfg0: W=64 registered, cfg1: W=64 direct, cfg2: W=8 registered, cfg3: W=8 direct
   for (genvar g = 0; g < 4; g++) begin : g_cfg
      localparam int CW   = (g < 2) ? 64 : 8;
      localparam bit CREG = (g % 2 == 0);

      logic          rst, ev, er, xv, xr;
      logic [CW-1:0] eb, b0, b1;
      logic [1:0]    xs, xsrc;
      int            mcount = 0;   // beats delivered since reset
      int            occ = 0;      // beats waiting in the registered front end
      int            sink_mode = 0;
      int            ratio = 0;
      bit            par = 1'b0;
      bit            acc = 1'b0;
      bit            live = 1'b0;
      logic [63:0]   exp_q [$];
      logic [63:0]   bits1_m = '0;

      rational_crossing_source #(.W(CW), .ENQ_REG(CREG)) dut (
         .clock     (clk),
         .reset     (rst),
         .enq_valid (ev),
         .enq_ready (er),
         .enq_bits  (eb),
         .x_bits0   (b0),
         .x_bits1   (b1),
         .x_valid   (xv),
         .x_source  (xsrc),
         .x_ready   (xr),
         .x_sink    (xs)
      );

      // Sink model. mode 0: in step and ready; 1: one token behind, not ready;
      // 2: ratio-driven (0 = 1:1, 1 = sink at half rate, 2 = sink at double rate).
      task automatic drive_sink();
         case (sink_mode)
            0: begin xs = tok(mcount); xr = 1'b1; end
            1: begin xs = tok(mcount + 3); xr = 1'b0; end
            default: begin
               case (ratio)
                  0: begin xs = tok(mcount); xr = ($urandom_range(3) != 0); end
                  1: begin
                     par = ~par;
                     if (par) begin xs = tok(mcount); xr = 1'b1; end
                     else begin xs = tok(mcount + 3); xr = 1'($urandom_range(1)); end
                  end
                  default: begin
                     xr = 1'b1;
                     xs = ($urandom_range(3) == 0) ? tok(mcount + 1) : tok(mcount);
                  end
               endcase
            end
         endcase
      endtask

      // One sender cycle of stimulus; an accepted beat goes onto the scoreboard.
      task automatic tick(input bit offer, input logic [63:0] val);
         @(negedge clk);
         if (acc) begin ev = 1'b0; acc = 1'b0; end
         drive_sink();
         if (!ev && offer) begin ev = 1'b1; eb = CW'(val); end
         #1;
         if (ev && er) begin
            acc = 1'b1;
            exp_q.push_back(64'(eb));
         end
      endtask

      task automatic do_reset();
         @(negedge clk);
         rst = 1'b1; ev = 1'b0; acc = 1'b0;
         drive_sink();
         @(negedge clk);
         rst = 1'b0;
         drive_sink();
      endtask

      // Driver
      initial begin
         rst = 1'b1; ev = 1'b0; eb = '0; xr = 1'b0; xs = 2'b00;
         do_reset();
         // single beat
         sink_mode = 0;
         tick(1'b1, 64'hA5);
         repeat (3) tick(1'b0, '0);
         // sink stalls with beats queued, then releases
         tick(1'b1, rnd()); tick(1'b1, rnd());
         sink_mode = 1;
         repeat (4) tick(1'b1, rnd());
         sink_mode = 0;
         repeat (6) tick(1'b0, '0);
         // token wrap, back to back
         for (int i = 0; i < 8; i++) tick(1'b1, rnd());
         repeat (3) tick(1'b0, '0);
         // held copy
         tick(1'b1, 64'h11); tick(1'b1, 64'h22);
         repeat (3) tick(1'b0, '0);
         // reset with beats pending and the token part-way round
         tick(1'b1, rnd()); tick(1'b1, rnd()); tick(1'b1, rnd());
         sink_mode = 1;
         tick(1'b1, rnd()); tick(1'b1, rnd());
         do_reset();
         sink_mode = 0;
         repeat (3) tick(1'b0, '0);
         // randomized traffic under each clock ratio
         for (int r = 0; r < 3; r++) begin
            sink_mode = 2; ratio = r;
            repeat (250) tick($urandom_range(9) < 7, rnd());
            sink_mode = 0;
            repeat (6) tick(1'b0, '0);
         end
         @(negedge clk); #3;
         check(g, "drain_empty", 64'(exp_q.size()), 64'd0);
         done[g] = 1'b1;
      end

      // Monitor: compares every cycle against the behavioural model and pops
      // the scoreboard whenever a beat crosses.
      initial begin
         logic [63:0] hb, exp_b;
         logic [1:0]  cur;
         logic        hv, eq, cond, exp_rdy, push;
         forever begin
            @(negedge clk); #2;
            if (rst) begin
               check(g, "rst_x_valid", 64'(xv), 64'd0);
               check(g, "rst_enq_ready", 64'(er), 64'd0);
               check(g, "rst_x_bits0", 64'(b0), 64'd0);
               exp_q.delete();
               occ = 0; mcount = 0; bits1_m = '0; live = 1'b1;
            end else if (live) begin
               cur = tok(mcount);
               if (CREG) begin
                  hv = (occ > 0);
                  hb = (hv && exp_q.size() > 0) ? exp_q[0] : 64'd0;
               end else begin
                  hv = ev;
                  hb = 64'(eb);
               end
               eq      = (cur == xs);
               cond    = eq ? xr : (cur[1] != xs[0]);
               exp_rdy = CREG ? (occ < 2) : cond;
               check(g, "x_valid", 64'(xv), 64'(hv));
               check(g, "enq_ready", 64'(er), 64'(exp_rdy));
               check(g, "x_source", 64'(xsrc), 64'(cur));
               check(g, "x_bits1", 64'(b1), bits1_m);
               if (hv && cond) begin
                  if (exp_q.size() == 0) begin
                     check(g, "sb_underflow", 64'd1, 64'd0);
                  end else begin
                     exp_b = exp_q.pop_front();
                     check(g, "beat_data", 64'(b0), exp_b);
                  end
                  mcount++;
               end else if (hv) begin
                  check(g, "held_x_bits0", 64'(b0), hb);
               end
               push = ev & exp_rdy;
               if (CREG) occ = occ + int'(push) - int'(hv && cond);
               if (eq) bits1_m = hb;
            end
         end
      end
   end

   initial begin
      fork
         wait (done[0] && done[1] && done[2] && done[3]);
         #200000;
      join_any
      if (!(done[0] && done[1] && done[2] && done[3]))
         check(-1, "timeout", 64'd0, 64'd1);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
